// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the combinational IM, and
// buffers up to two {pc, instr} pairs for decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 2;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [AW-1:0] ent_pc_q [2];
  logic [AW-1:0] ent_pc_d [2];
  logic [31:0]   ent_instr_q [2];
  logic [31:0]   ent_instr_d [2];
  logic          head_q, head_d;
  logic [CW-1:0] count_q, count_d;

  logic pop_c;
  logic push_c;
  logic tail_c;

  assign im_addr   = pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = ent_instr_q[head_q];
  assign out_pc    = ent_pc_q[head_q];
  assign fetch_cnt = fetch_cnt_q;

  // Next-state: redirect flushes and reloads PC, otherwise push/pop the ring.
  always_comb begin
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    ent_pc_d    = ent_pc_q;
    ent_instr_d = ent_instr_q;
    head_d      = head_q;
    count_d     = count_q;

    pop_c  = out_valid & out_ready;
    push_c = ~redirect_valid & ~halt & ((count_q < CW'(DEPTH)) | pop_c);
    // Tail sits count entries past head; when full it aliases the slot being popped.
    tail_c = head_q ^ count_q[0];

    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      count_d = '0;
    end else begin
      if (push_c) begin
        ent_pc_d[tail_c]    = pc_q;
        ent_instr_d[tail_c] = im_instr;
        pc_d                = pc_q + ADDR_STEP;
        fetch_cnt_d         = fetch_cnt_q + 32'd1;
      end
      if (pop_c) begin
        head_d = ~head_q;
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q           <= RESET_PC;
      fetch_cnt_q    <= '0;
      ent_pc_q[0]    <= '0;
      ent_pc_q[1]    <= '0;
      ent_instr_q[0] <= '0;
      ent_instr_q[1] <= '0;
      head_q         <= 1'b0;
      count_q        <= '0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      ent_pc_q    <= ent_pc_d;
      ent_instr_q <= ent_instr_d;
      head_q      <= head_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, async reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset_n;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_cnt      (fetch_cnt)
  );

  // IM model: word at address N is 32'h1000_0000 + N.
  assign im_instr = 32'h1000_0000 + im_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ready;
    logic        redir;
    logic        hlt;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [31:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  vec_t vecs [27];

  ent_t        mq [$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic r, input logic rd, input logic h,
                         input logic [31:0] rpc, input logic v, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] c);
    vecs[i].ready = r;  vecs[i].redir = rd; vecs[i].hlt = h; vecs[i].rpc = rpc;
    vecs[i].exp_valid = v; vecs[i].exp_pc = p; vecs[i].exp_addr = a; vecs[i].exp_cnt = c;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    mq.delete();
    m_pc  = 32'h0;
    m_cnt = 32'h0;
  endtask

  // Reference step: apply one clock edge's worth of the fetch rules.
  task automatic model_step(input logic r, input logic rd, input logic h, input logic [31:0] rpc);
    bit pop;
    bit push;
    pop = (mq.size() != 0) && r;
    if (rd) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      push = !h && (mq.size() < 2 || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: m_pc, instr: 32'h1000_0000 + m_pc});
        m_pc  = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;

    // Reset release/streaming, backpressure, redirect while full, halt, wrap,
    // redirect while halted.
    set_vec( 0, 1, 0, 0, 32'h0,         1, 32'h0,         32'h4,         32'd1);
    set_vec( 1, 1, 0, 0, 32'h0,         1, 32'h4,         32'h8,         32'd2);
    set_vec( 2, 1, 0, 0, 32'h0,         1, 32'h8,         32'hC,         32'd3);
    set_vec( 3, 1, 0, 0, 32'h0,         1, 32'hC,         32'h10,        32'd4);
    set_vec( 4, 1, 0, 0, 32'h0,         1, 32'h10,        32'h14,        32'd5);
    set_vec( 5, 0, 0, 0, 32'h0,         1, 32'h10,        32'h18,        32'd6);
    set_vec( 6, 0, 0, 0, 32'h0,         1, 32'h10,        32'h18,        32'd6);
    set_vec( 7, 1, 0, 0, 32'h0,         1, 32'h14,        32'h1C,        32'd7);
    set_vec( 8, 1, 0, 0, 32'h0,         1, 32'h18,        32'h20,        32'd8);
    set_vec( 9, 0, 0, 0, 32'h0,         1, 32'h18,        32'h20,        32'd8);
    set_vec(10, 0, 1, 0, 32'h0000_0103, 0, 32'h0,         32'h100,       32'd8);
    set_vec(11, 1, 0, 0, 32'h0,         1, 32'h100,       32'h104,       32'd9);
    set_vec(12, 1, 0, 0, 32'h0,         1, 32'h104,       32'h108,       32'd10);
    set_vec(13, 1, 1, 0, 32'h18,        0, 32'h0,         32'h18,        32'd10);
    set_vec(14, 0, 0, 0, 32'h0,         1, 32'h18,        32'h1C,        32'd11);
    set_vec(15, 0, 0, 0, 32'h0,         1, 32'h18,        32'h20,        32'd12);
    set_vec(16, 1, 0, 1, 32'h0,         1, 32'h1C,        32'h20,        32'd12);
    set_vec(17, 1, 0, 1, 32'h0,         0, 32'h0,         32'h20,        32'd12);
    set_vec(18, 1, 0, 1, 32'h0,         0, 32'h0,         32'h20,        32'd12);
    set_vec(19, 1, 0, 0, 32'h0,         1, 32'h20,        32'h24,        32'd13);
    set_vec(20, 1, 1, 0, 32'hFFFF_FFFC, 0, 32'h0,         32'hFFFF_FFFC, 32'd13);
    set_vec(21, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0,         32'd14);
    set_vec(22, 1, 0, 0, 32'h0,         1, 32'h0,         32'h4,         32'd15);
    set_vec(23, 1, 0, 0, 32'h0,         1, 32'h4,         32'h8,         32'd16);
    set_vec(24, 0, 1, 1, 32'h40,        0, 32'h0,         32'h40,        32'd16);
    set_vec(25, 0, 0, 1, 32'h0,         0, 32'h0,         32'h40,        32'd16);
    set_vec(26, 1, 0, 0, 32'h0,         1, 32'h40,        32'h44,        32'd17);

    // Reset state while held in reset.
    @(negedge clock);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_addr",  im_addr,        32'h0);
    chk("rst_pc",    out_pc,         32'h0);
    chk("rst_instr", out_instr,      32'h0);
    chk("rst_cnt",   fetch_cnt,      32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      out_ready      = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      halt           = vecs[i].hlt;
      redirect_pc    = vecs[i].rpc;
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_addr", i),  im_addr,        vecs[i].exp_addr);
      chk($sformatf("vec%0d_cnt", i),   fetch_cnt,      vecs[i].exp_cnt);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i),    out_pc,    vecs[i].exp_pc);
        chk($sformatf("vec%0d_instr", i), out_instr, 32'h1000_0000 + vecs[i].exp_pc);
      end
      @(negedge clock);
    end

    // Async reset between edges with a full buffer.
    do_reset();
    out_ready = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("pre_arst_addr", im_addr, 32'h8);
    chk("pre_arst_pc",   out_pc,  32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_addr",  im_addr,        32'h0);
    chk("arst_cnt",   fetch_cnt,      32'h0);
    @(negedge clock);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      halt           = ($urandom_range(0, 9) < 2);
      redirect_pc    = $urandom();
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | (redirect_pc & 32'hF);
      model_step(out_ready, redirect_valid, halt, redirect_pc);
      @(posedge clock);
      #1;
      chk($sformatf("rnd%0d_valid", i), 32'(out_valid), 32'(mq.size() != 0));
      chk($sformatf("rnd%0d_addr", i),  im_addr,        m_pc);
      chk($sformatf("rnd%0d_cnt", i),   fetch_cnt,      m_cnt);
      if (mq.size() != 0) begin
        chk($sformatf("rnd%0d_pc", i),    out_pc,    mq[0].pc);
        chk($sformatf("rnd%0d_instr", i), out_instr, mq[0].instr);
      end
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the combinational instruction memory: owns the PC, drives the IM address, and captures {pc, instr} pairs into a 2-entry prefetch buffer.
- Presents buffered instructions to decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush the buffer, and a halt request that freezes fetching.
- Sits between the PC/branch logic and decode, in front of IM.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_STEP, 4, PC increment per fetched instruction (byte addressing, word-aligned).
- DEPTH, 2, prefetch buffer entries; fixed at 2, other values unsupported.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- im_addr  output  32  address to IM; always equals current pc.
- im_instr  input  32  IM read data; combinational function of im_addr.
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  32  instruction at buffer head.
- out_pc  output  32  address of out_instr.
- redirect_valid  input  1  load new PC and flush the buffer.
- redirect_pc  input  32  redirect target; bits [1:0] are forced to 0.
- halt  input  1  suppresses fetching while high; the buffer still drains.
- fetch_cnt  output  32  count of instructions captured since reset (wraps).

Behaviour:
- Reset (reset_n low, asynchronous):
  - pc = RESET_PC; buffer empty (count 0).
  - out_valid = 0; out_instr = 0; out_pc = 0; fetch_cnt = 0.
  - Reset asserted mid-operation discards all buffered entries immediately.
- im_addr = pc, combinationally at all times.
- pop = out_valid & out_ready.
- push = !redirect_valid & !halt & (count < 2 | pop).
- Each rising edge, priority order:
  1. redirect_valid:
     - pc <= {redirect_pc[31:2], 2'b00}; count <= 0.
     - No push that edge.
     - A pop in the same cycle still counts as a completed handshake; decode must treat it as accepted.
     - fetch_cnt is unchanged.
  2. Otherwise, push and/or pop:
     - push writes {pc, im_instr} at the tail; pc <= pc + ADDR_STEP, mod 2^32 (32'hFFFF_FFFC wraps to 0).
     - fetch_cnt += 1 per push.
     - pop advances the head.
     - Push and pop together keep count unchanged. When count = 2 this refills the slot just freed; order is preserved.
  3. Neither: all state holds; pc holds while full or halted.
- Latency: one edge after reset deassertion (or after a redirect), out_valid = 1 with out_pc = loaded pc. Sustained throughput is 1 instr/cycle while out_ready = 1.
- out_valid = (count != 0). out_instr/out_pc show the head entry and are stable while out_valid & !out_ready.
- An empty buffer with pop is impossible (out_valid = 0). Full with no pop: no push, im_addr still shows the next pc.
- halt asserted: no pushes; pops continue. halt deasserted: fetch resumes from the held pc, nothing skipped.
- redirect while halted: pc still loads and the buffer still flushes.
- Buffer is implemented as 2 registers plus a head pointer and 2-bit count. No combinational path from out_ready to im_addr.

Test Plan:
- Reset release, IM word at addr N = 32'h1000_0000+N, out_ready = 1:
  - Outputs after successive edges: (pc 0, 32'h1000_0000), (pc 4, 32'h1000_0004), (pc 8, ...), one per cycle.
  - fetch_cnt = 5 after 5 edges.
- Backpressure, out_ready = 0 from reset:
  - After 2 edges count = 2, im_addr = 8, out_pc = 0 held.
  - Raise out_ready: outputs pc 0, 4, 8 on consecutive cycles with no gap or duplicate.
- Redirect while full:
  - redirect_valid = 1, redirect_pc = 32'h0000_0103 -> next edge pc = 32'h100, out_valid = 0.
  - Following edge: out_valid = 1, out_pc = 32'h100.
  - Stale entries 0/4 never appear.
- Halt:
  - Assert halt at pc = 32'h20 with 2 buffered entries and out_ready = 1 -> 2 outputs, then out_valid = 0; im_addr stays 32'h20 and fetch_cnt is frozen.
  - Deassert halt -> out_pc = 32'h20 next.
- Wrap:
  - Redirect to 32'hFFFF_FFFC -> outputs pc FFFF_FFFC, then 0000_0000, then 0000_0004.
- Async reset mid-stream:
  - Drop reset_n between edges with count = 2 -> out_valid = 0 and im_addr = RESET_PC immediately, without waiting for a clock edge.
